// File: rtl/uart_gpio_bridge.sv
// Byte-command bridge between a UART AXI-Stream pair and banks of 8-bit GPIO ports.
// Commands: 'W' addr data -> ACK, 'R' addr -> addr value; input changes reported as 'C' idx value.
module uart_gpio_bridge #(
  parameter int NUM_OUT     = 4,
  parameter int NUM_IN      = 4,
  parameter int CMD_TIMEOUT = 8000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [7:0]           m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [NUM_OUT*8-1:0] gpio_out,
  input  logic [NUM_IN*8-1:0]  gpio_in,
  input  logic                 notify_en,
  output logic                 err
);

  localparam int TW = $clog2(CMD_TIMEOUT + 1);
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;
  localparam logic [7:0] NOTE = 8'h43;

  typedef enum logic [2:0] {IDLE, CMD_ADDR, CMD_DATA, EXEC, TX} state_t;

  state_t          state_q;
  logic [7:0]      op_q, addr_q, data_q;
  logic [TW-1:0]   idle_q;
  logic [7:0]      buf_q [3];
  logic [1:0]      cnt_q, idx_q;
  logic [7:0]      m_tdata_q;
  logic            m_tvalid_q, err_q;

  logic [NUM_IN*8-1:0] sync_vec;
  logic [NUM_IN-1:0]   diff;
  logic                accept, notify_hit, notify_fire, rd_ok, wr_ok;
  logic [7:0]          notify_idx, notify_val, rd_val;

  assign s_tready = rst_n && (state_q == IDLE || state_q == CMD_ADDR || state_q == CMD_DATA);
  assign accept   = s_tvalid && s_tready;
  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign err      = err_q;
  assign rd_ok    = addr_q < 8'(NUM_IN);
  assign wr_ok    = addr_q < 8'(NUM_OUT);
  assign notify_fire = (state_q == IDLE) && !s_tvalid && notify_en && notify_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      logic [7:0] meta_q, sync_q, last_q;
      // Synchronizer flops stay un-reset so the reset-time copy load sees live inputs.
      always_ff @(posedge clk) begin
        meta_q <= gpio_in[gi*8 +: 8];
        sync_q <= meta_q;
      end
      always_ff @(posedge clk) begin
        if (!rst_n || !notify_en)
          last_q <= sync_q;
        else if (notify_fire && notify_idx == 8'(gi))
          last_q <= sync_q;
      end
      assign sync_vec[gi*8 +: 8] = sync_q;
      assign diff[gi] = (sync_q != last_q);
    end

    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      logic [7:0] out_q;
      always_ff @(posedge clk) begin
        if (!rst_n)
          out_q <= 8'h00;
        else if (state_q == EXEC && op_q == OP_W && addr_q == 8'(gi))
          out_q <= data_q;
      end
      assign gpio_out[gi*8 +: 8] = out_q;
    end
  endgenerate

  always_comb begin
    rd_val = 8'h00;
    for (int k = 0; k < NUM_IN; k++)
      if (addr_q == 8'(k)) rd_val = sync_vec[k*8 +: 8];
  end

  // Scanning downwards leaves the lowest changed index as the winner.
  always_comb begin
    notify_hit = 1'b0;
    notify_idx = 8'h00;
    notify_val = 8'h00;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (diff[k]) begin
        notify_hit = 1'b1;
        notify_idx = 8'(k);
        notify_val = sync_vec[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 8'h00;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      idle_q     <= '0;
      buf_q[0]   <= 8'h00;
      buf_q[1]   <= 8'h00;
      buf_q[2]   <= 8'h00;
      cnt_q      <= 2'd0;
      idx_q      <= 2'd0;
      m_tdata_q  <= 8'h00;
      m_tvalid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (s_tdata == OP_W || s_tdata == OP_R) begin
              op_q    <= s_tdata;
              idle_q  <= '0;
              state_q <= CMD_ADDR;
            end else begin
              buf_q[0]   <= NAK;
              cnt_q      <= 2'd1;
              idx_q      <= 2'd1;
              m_tdata_q  <= NAK;
              m_tvalid_q <= 1'b1;
              err_q      <= 1'b1;
              state_q    <= TX;
            end
          end else if (notify_fire) begin
            buf_q[0]   <= NOTE;
            buf_q[1]   <= notify_idx;
            buf_q[2]   <= notify_val;
            cnt_q      <= 2'd3;
            idx_q      <= 2'd1;
            m_tdata_q  <= NOTE;
            m_tvalid_q <= 1'b1;
            state_q    <= TX;
          end
        end
        CMD_ADDR, CMD_DATA: begin
          if (accept) begin
            idle_q <= '0;
            if (state_q == CMD_ADDR) begin
              addr_q  <= s_tdata;
              state_q <= (op_q == OP_W) ? CMD_DATA : EXEC;
            end else begin
              data_q  <= s_tdata;
              state_q <= EXEC;
            end
          end else if (idle_q == TW'(CMD_TIMEOUT - 1)) begin
            idle_q  <= '0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        EXEC: begin
          m_tvalid_q <= 1'b1;
          idx_q      <= 2'd1;
          state_q    <= TX;
          if (op_q == OP_W && wr_ok) begin
            buf_q[0]  <= ACK;
            cnt_q     <= 2'd1;
            m_tdata_q <= ACK;
          end else if (op_q == OP_R && rd_ok) begin
            buf_q[0]  <= addr_q;
            buf_q[1]  <= rd_val;
            cnt_q     <= 2'd2;
            m_tdata_q <= addr_q;
          end else begin
            buf_q[0]  <= NAK;
            cnt_q     <= 2'd1;
            m_tdata_q <= NAK;
            err_q     <= 1'b1;
          end
        end
        TX: begin
          if (m_tready) begin
            if (idx_q == cnt_q) begin
              m_tvalid_q <= 1'b0;
              m_tdata_q  <= 8'h00;
              state_q    <= IDLE;
            end else begin
              m_tdata_q <= buf_q[idx_q];
              idx_q     <= idx_q + 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
